// File: rtl/tile_result_drain.sv
// ============================================================================
// tile_result_drain
// ----------------------------------------------------------------------------
// Purpose:
//   Snapshots the full parallel result vector of a tile array on a one-cycle
//   capture strobe, then streams it out as NBEAT = ROWS*T_ROWS beats of
//   COLS elements each over a valid/ready handshake. Beat 0 is the LSB slice
//   of the snapshot; beats leave in ascending order. A capture that arrives
//   while a drain is still in progress is dropped and recorded in a sticky
//   overrun flag. The one exception is a capture in the same cycle as the
//   final handshake: it is accepted and starts a new drain back-to-back.
//
// Optional feature:
//   DRAIN_RELU_EN - when defined, every M_BW element of o_data is treated as
//                   two's complement and clamped to zero if negative. This is
//                   purely combinational on the snapshot and adds no latency.
//                   When undefined, snapshot elements pass through unchanged.
//
// Parameters:
//   M_BW    bit width of one result element
//   COLS    elements per beat (PE columns per tile)
//   ROWS    PE rows per tile
//   T_ROWS  tile rows
//
// Ports:
//   clk           single rising-edge clock
//   rst           asynchronous active-high reset
//   i_capture     one-cycle strobe that snapshots i_mul_result
//   i_mul_result  parallel result vector (M_BW*COLS*ROWS*T_ROWS bits)
//   i_ready       downstream ready
//   i_clr_ovr     clears o_overrun (a simultaneous set wins)
//   o_data        current beat (M_BW*COLS bits)
//   o_valid       beat valid, high exactly while draining
//   o_last        high on beat NBEAT-1
//   o_beat_idx    current beat index
//   o_busy        high while a drain is in progress
//   o_done        one-cycle pulse in the cycle after the final handshake
//   o_overrun     sticky flag: a capture was lost while busy
// ============================================================================
module tile_result_drain #(
    parameter int M_BW   = 16,
    parameter int COLS   = 5,
    parameter int ROWS   = 5,
    parameter int T_ROWS = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_capture,
    input  logic [M_BW*COLS*ROWS*T_ROWS-1:0]   i_mul_result,
    input  logic                               i_ready,
    input  logic                               i_clr_ovr,
    output logic [M_BW*COLS-1:0]               o_data,
    output logic                               o_valid,
    output logic                               o_last,
    output logic [$clog2(ROWS*T_ROWS)-1:0]     o_beat_idx,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_overrun
);

    localparam int NBEAT  = ROWS * T_ROWS;
    localparam int BEAT_W = M_BW * COLS;
    localparam int BIW    = $clog2(NBEAT);

    localparam logic [BIW-1:0] LAST_BEAT = BIW'(NBEAT - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                          state;
    logic [BIW-1:0]                  beat;
    // Beat-major view of the snapshot: snapshot[k] is beat k, so the packed
    // layout matches i_mul_result bit-for-bit with beat 0 in the LSBs.
    logic [NBEAT-1:0][BEAT_W-1:0]    snapshot;

    logic                            draining;
    logic                            handshake;
    logic                            final_hs;
    logic                            accept_cap;
    logic                            lost_cap;
    logic [BEAT_W-1:0]               beat_raw;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign draining  = (state == ST_DRAIN);
    assign handshake = draining && i_ready;
    assign final_hs  = handshake && (beat == LAST_BEAT);

    // A capture is taken when idle, or when it coincides with the final
    // handshake so a new drain follows the old one with no idle gap.
    assign accept_cap = i_capture && (!draining || final_hs);
    assign lost_cap   = i_capture && draining && !final_hs;

    // ------------------------------------------------------------------------
    // FSM, beat counter, snapshot and status flags
    // ------------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all right-hand sides
    // see the pre-edge values; blocking = would let later statements observe
    // already-updated state and silently change the machine's behaviour.
    // NOTE: the snapshot is reset along with the control state because
    // o_data must read zero during reset; without that requirement the wide
    // data register would normally be left unreset to save reset routing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat      <= '0;
            snapshot  <= '0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_done <= final_hs;

            // Set has priority over clear so a loss in the clear cycle is
            // never hidden.
            if (lost_cap) begin
                o_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                o_overrun <= 1'b0;
            end

            if (accept_cap) begin
                snapshot <= i_mul_result;
                beat     <= '0;
                state    <= ST_DRAIN;
            end else if (final_hs) begin
                // Counter holds at the last beat instead of wrapping.
                state <= ST_IDLE;
            end else if (handshake) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs decoded directly from registered state
    // ------------------------------------------------------------------------
    assign o_valid    = draining;
    assign o_busy     = draining;
    assign o_last     = draining && (beat == LAST_BEAT);
    assign o_beat_idx = beat;
    assign beat_raw   = snapshot[beat];

`ifdef DRAIN_RELU_EN
    // Clamp each two's-complement element at zero.
    // NOTE: o_data gets a full default before the loop so every bit is
    // assigned on every pass; a path that left bits unassigned would infer
    // latches in this combinational block.
    always_comb begin
        o_data = '0;
        for (int j = 0; j < COLS; j++) begin
            if (!beat_raw[j*M_BW + M_BW - 1]) begin
                o_data[j*M_BW +: M_BW] = beat_raw[j*M_BW +: M_BW];
            end
        end
    end
`else
    assign o_data = beat_raw;
`endif

endmodule

// File: tb/tb_tile_result_drain.sv
// ============================================================================
// tb_tile_result_drain
// ----------------------------------------------------------------------------
// Self-checking bench for tile_result_drain. A scoreboard queue receives the
// expected beats whenever the bench drives a capture the design should
// accept; each handshake pops and compares one beat. Per-cycle checks cover
// valid/busy/last/done/overrun against a small model, and stalled beats must
// hold stable. A table of element values exercises the ReLU option (or
// pass-through) and sign boundaries.
// ============================================================================
module tb_tile_result_drain;

    localparam int M_BW   = 16;
    localparam int COLS   = 5;
    localparam int ROWS   = 5;
    localparam int T_ROWS = 5;
    localparam int NBEAT  = ROWS * T_ROWS;
    localparam int BEAT_W = M_BW * COLS;
    localparam int TOT_W  = BEAT_W * NBEAT;
    localparam int BIW    = $clog2(NBEAT);

    typedef logic [BEAT_W-1:0] word_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_capture;
    logic [TOT_W-1:0]     i_mul_result;
    logic                 i_ready;
    logic                 i_clr_ovr;
    logic [BEAT_W-1:0]    o_data;
    logic                 o_valid;
    logic                 o_last;
    logic [BIW-1:0]       o_beat_idx;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_overrun;

    tile_result_drain #(
        .M_BW   (M_BW),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .T_ROWS (T_ROWS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_capture    (i_capture),
        .i_mul_result (i_mul_result),
        .i_ready      (i_ready),
        .i_clr_ovr    (i_clr_ovr),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_last       (o_last),
        .o_beat_idx   (o_beat_idx),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t data;
        int    idx;
        logic  last;
    } beat_t;

    typedef struct {
        logic [M_BW-1:0] elem;
        logic [M_BW-1:0] exp_out;
    } vec_t;

    beat_t           sb_q[$];
    logic [M_BW-1:0] elems[NBEAT][COLS];
    int              n_cmp = 0;
    int              n_err = 0;
    logic            ovr_exp = 1'b0;
    logic            done_exp = 1'b0;
    logic            stall_pend = 1'b0;
    word_t           stall_data;
    logic [BIW-1:0]  stall_idx;
    logic            stall_last;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [M_BW-1:0] relu_model(input logic [M_BW-1:0] x);
`ifdef DRAIN_RELU_EN
        return x[M_BW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic fill_pattern();
        for (int k = 0; k < NBEAT; k++)
            for (int j = 0; j < COLS; j++)
                elems[k][j] = M_BW'(k * COLS + j);
    endtask

    task automatic fill_const(input logic [M_BW-1:0] v);
        for (int k = 0; k < NBEAT; k++)
            for (int j = 0; j < COLS; j++)
                elems[k][j] = v;
    endtask

    task automatic drive_vector();
        for (int k = 0; k < NBEAT; k++)
            for (int j = 0; j < COLS; j++)
                i_mul_result[(k*COLS + j)*M_BW +: M_BW] = elems[k][j];
    endtask

    task automatic push_expected();
        beat_t b;
        for (int k = 0; k < NBEAT; k++) begin
            b.data = '0;
            for (int j = 0; j < COLS; j++)
                b.data[j*M_BW +: M_BW] = relu_model(elems[k][j]);
            b.idx  = k;
            b.last = (k == NBEAT - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: apply inputs, score any handshake against the queue,
    // update the model, clock, then check the registered status outputs.
    task automatic cycle(input logic rdy, input logic cap, input logic clr);
        logic  busy_m;
        logic  hs;
        logic  last_hs;
        beat_t b;
        busy_m    = (sb_q.size() != 0);
        i_ready   = rdy;
        i_capture = cap;
        i_clr_ovr = clr;
        if (stall_pend) begin
            check("stall_data", o_data, stall_data);
            check("stall_idx", word_t'(o_beat_idx), word_t'(stall_idx));
            check("stall_last", word_t'(o_last), word_t'(stall_last));
            stall_pend = 1'b0;
        end
        hs      = busy_m && rdy;
        last_hs = 1'b0;
        if (hs) begin
            b = sb_q.pop_front();
            check("beat_data", o_data, b.data);
            check("beat_idx", word_t'(o_beat_idx), word_t'(b.idx));
            check("beat_last", word_t'(o_last), word_t'(b.last));
            last_hs = b.last;
        end else if (busy_m) begin
            stall_pend = 1'b1;
            stall_data = o_data;
            stall_idx  = o_beat_idx;
            stall_last = o_last;
        end
        if (cap) begin
            drive_vector();
            if (!busy_m || last_hs) push_expected();
        end
        if (cap && busy_m && !last_hs) ovr_exp = 1'b1;
        else if (clr)                  ovr_exp = 1'b0;
        done_exp = last_hs;
        tick();
        i_capture = 1'b0;
        i_clr_ovr = 1'b0;
        check("valid", word_t'(o_valid), word_t'(sb_q.size() != 0));
        check("busy", word_t'(o_busy), word_t'(sb_q.size() != 0));
        check("done", word_t'(o_done), word_t'(done_exp));
        check("overrun", word_t'(o_overrun), word_t'(ovr_exp));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", word_t'(sb_q.size()), '0);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   n;
        int   c;
        logic rdy;

`ifdef DRAIN_RELU_EN
        vecs[0] = '{16'hFFF0, 16'h0000};
        vecs[1] = '{16'h0010, 16'h0010};
        vecs[2] = '{16'h8000, 16'h0000};
        vecs[3] = '{16'h7FFF, 16'h7FFF};
        vecs[4] = '{16'h0000, 16'h0000};
`else
        vecs[0] = '{16'hFFF0, 16'hFFF0};
        vecs[1] = '{16'h0010, 16'h0010};
        vecs[2] = '{16'h8000, 16'h8000};
        vecs[3] = '{16'h7FFF, 16'h7FFF};
        vecs[4] = '{16'h0000, 16'h0000};
`endif

        rst          = 1'b1;
        i_capture    = 1'b0;
        i_ready      = 1'b0;
        i_clr_ovr    = 1'b0;
        i_mul_result = '0;
        #12;
        check("rst_valid", word_t'(o_valid), '0);
        check("rst_last", word_t'(o_last), '0);
        check("rst_done", word_t'(o_done), '0);
        check("rst_busy", word_t'(o_busy), '0);
        check("rst_overrun", word_t'(o_overrun), '0);
        check("rst_idx", word_t'(o_beat_idx), '0);
        check("rst_data", o_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ready: 26 cycles from capture to o_done.
        fill_pattern();
        cycle(1'b1, 1'b1, 1'b0);
        n = 1;
        while (!o_done && n < 100) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("latency_capture_to_done", word_t'(n), word_t'(26));
        cycle(1'b1, 1'b0, 1'b0);

        // Ready pattern 1,0,0,1 repeating.
        fill_pattern();
        cycle(1'b0, 1'b1, 1'b0);
        c = 0;
        while (sb_q.size() != 0 && c < 400) begin
            rdy = ((c % 4) == 0) || ((c % 4) == 3);
            cycle(rdy, 1'b0, 1'b0);
            c++;
        end
        check("stall_drain_complete", word_t'(sb_q.size()), '0);
        sb_q.delete();
        cycle(1'b0, 1'b0, 1'b0);

        // Lost capture at beat 10, set-beats-clear, then clear.
        fill_pattern();
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
        check("ovr_at_beat10_idx", word_t'(o_beat_idx), word_t'(10));
        fill_const(16'h1234);
        cycle(1'b1, 1'b1, 1'b0);
        check("ovr_set", word_t'(o_overrun), word_t'(1));
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("ovr_set_beats_clear", word_t'(o_overrun), word_t'(1));
        drain(60);
        cycle(1'b0, 1'b0, 1'b0);
        check("ovr_sticky", word_t'(o_overrun), word_t'(1));
        cycle(1'b0, 1'b0, 1'b1);
        check("ovr_cleared", word_t'(o_overrun), '0);

        // Capture in the final-handshake cycle with 0xA5A5 data.
        fill_pattern();
        cycle(1'b1, 1'b1, 1'b0);
        n = 0;
        while (sb_q.size() > 1 && n < 60) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("final_beat_last", word_t'(o_last), word_t'(1));
        fill_const(16'hA5A5);
        cycle(1'b1, 1'b1, 1'b0);
        check("b2b_done", word_t'(o_done), word_t'(1));
        check("b2b_idx0", word_t'(o_beat_idx), '0);
        check("b2b_valid", word_t'(o_valid), word_t'(1));
        check("b2b_no_ovr", word_t'(o_overrun), '0);
        drain(60);
        cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset at beat 7.
        fill_pattern();
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
        check("pre_rst_idx", word_t'(o_beat_idx), word_t'(7));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", word_t'(o_valid), '0);
        check("async_rst_busy", word_t'(o_busy), '0);
        check("async_rst_idx", word_t'(o_beat_idx), '0);
        check("async_rst_data", o_data, '0);
        check("async_rst_done", word_t'(o_done), '0);
        sb_q.delete();
        ovr_exp    = 1'b0;
        done_exp   = 1'b0;
        stall_pend = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        fill_pattern();
        cycle(1'b1, 1'b1, 1'b0);
        check("restart_idx0", word_t'(o_beat_idx), '0);
        drain(60);
        cycle(1'b0, 1'b0, 1'b0);

        // Element table: ReLU clamp or pass-through, sign boundaries.
        for (int i = 0; i < 5; i++) begin
            fill_const(vecs[i].elem);
            cycle(1'b0, 1'b1, 1'b0);
            check("vec_beat0", o_data, {COLS{vecs[i].exp_out}});
            drain(60);
            cycle(1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tile_result_drain.md
TILE_RESULT_DRAIN -- requirements
Module: tile_result_drain

Interface
REQ-001 SHALL have parameter M_BW, default 16, meaning the bit width of one result element.
REQ-002 SHALL have parameter COLS, default 5, meaning elements per beat (PE columns per tile).
REQ-003 SHALL have parameter ROWS, default 5, meaning PE rows per tile.
REQ-004 SHALL have parameter T_ROWS, default 5, meaning tile rows; NBEAT = ROWS*T_ROWS (default 25).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port i_capture, input, 1 bit, a one-cycle strobe that snapshots the array results.
REQ-008 SHALL have port i_mul_result, input, M_BW*COLS*ROWS*T_ROWS bits, the parallel result vector from the tile array.
REQ-009 SHALL have port i_ready, input, 1 bit, the downstream ready.
REQ-010 SHALL have port i_clr_ovr, input, 1 bit, which clears o_overrun.
REQ-011 SHALL have port o_data, output, M_BW*COLS bits, the current beat.
REQ-012 SHALL have port o_valid, output, 1 bit, beat valid.
REQ-013 SHALL have port o_last, output, 1 bit, asserted on beat NBEAT-1.
REQ-014 SHALL have port o_beat_idx, output, $clog2(NBEAT) bits, the current beat index.
REQ-015 SHALL have port o_busy, output, 1 bit, high while a drain is in progress.
REQ-016 SHALL have port o_done, output, 1 bit, a one-cycle pulse after the final handshake.
REQ-017 SHALL have port o_overrun, output, 1 bit, a sticky flag for a capture lost while busy.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and DRAIN.
REQ-019 In IDLE, i_capture=1 SHALL register i_mul_result into a snapshot register, clear the beat counter to 0, and enter DRAIN on the same edge.
REQ-020 o_valid SHALL be 1 exactly when the state is DRAIN; the first valid beat appears in the cycle after the capture edge (latency 1).
REQ-021 Beat k SHALL be snapshot bits [(k+1)*M_BW*COLS-1 : k*M_BW*COLS], with beat 0 as the LSB slice, and beats SHALL be emitted in ascending k.
REQ-022 A handshake (o_valid & i_ready) SHALL advance the beat counter by 1; o_data, o_last and o_beat_idx SHALL hold stable while o_valid & !i_ready.
REQ-023 o_last SHALL equal (state==DRAIN) & (beat==NBEAT-1).
REQ-024 A handshake on the last beat SHALL return the FSM to IDLE and pulse o_done for one cycle; the counter SHALL NOT wrap past NBEAT-1.
REQ-025 i_capture during DRAIN, except in the final-handshake cycle, SHALL be ignored (the snapshot is unchanged) and SHALL set o_overrun.
REQ-026 i_capture in the same cycle as the final handshake SHALL be accepted: a new snapshot is taken, beat is set to 0, the state stays DRAIN, o_done still pulses, and no overrun is flagged.
REQ-027 o_overrun SHALL remain set until i_clr_ovr=1.
REQ-028 If a set condition and i_clr_ovr occur in the same cycle, the set SHALL win.
REQ-029 o_busy SHALL equal (state==DRAIN).
REQ-030 i_mul_result SHALL be sampled only on an accepted capture; at all other times it is don't-care.

Reset
REQ-031 When rst=1 the block SHALL immediately enter IDLE, asynchronously to clk.
REQ-032 During reset: beat=0, o_valid=0, o_last=0, o_done=0, o_busy=0, o_overrun=0, o_beat_idx=0, and the snapshot and o_data are 0.
REQ-033 Reset mid-drain SHALL discard the remaining beats with no o_done pulse.
REQ-034 After reset deassertion the first accepted capture SHALL behave per REQ-019.

Configuration
REQ-035 SHALL support macro DRAIN_RELU_EN.
REQ-036 When DRAIN_RELU_EN is defined, each M_BW element of o_data SHALL be treated as two's-complement and output as 0 if negative, otherwise unchanged; this is combinational on the snapshot, with no added latency.
REQ-037 When DRAIN_RELU_EN is undefined, o_data SHALL pass snapshot elements unmodified.

Verification
REQ-038 Capture with element e(k,j)=k*COLS+j and i_ready held at 1 -> 25 consecutive beats, beat k elements = 5k..5k+4, o_last on beat 24, o_done one cycle later, total 26 cycles from capture.
REQ-039 i_ready toggling 1,0,0,1 repeating -> the same 25 beats in order, with o_data stable across every stall cycle and no beat duplicated or skipped.
REQ-040 Capture again at beat 10 -> o_overrun=1, remaining beats are the original data; i_clr_ovr pulse -> o_overrun=0.
REQ-041 Capture in the final-handshake cycle with new data 0xA5A5 in every element -> o_done pulses, beat 0 of the new data follows the next cycle, and o_overrun stays 0.
REQ-042 rst asserted at beat 7 -> o_valid=0 at once with no o_done; a new capture afterwards restarts at beat 0.
REQ-043 With DRAIN_RELU_EN, element 0xFFF0 -> output 0x0000 and element 0x0010 -> 0x0010; without the macro, 0xFFF0 passes unchanged.
